lut_breadboard: RTL
===================

Name: lut_breadboard

Overview:
Parametrised, clocked successor to the team's fixed four-input/ten-output combinational breadboard.
- Holds a programmable truth table: 2^N_IN rows, each N_OUT bits wide.
- Evaluates single input vectors through a registered valid/ready pipeline.
- Offers a hardware sweep mode that emits every row in index order, replacing the manual testbench enumeration loop.
- Sits between the lab stimulus logic and the display/checker logic.

Parameters:
- N_IN, 4, number of input variables; table depth DEPTH = 2**N_IN.
- N_OUT, 10, number of output functions (row width).
- INIT, {N_OUT*DEPTH{1'b0}}, table contents loaded at reset; row k occupies bits [k*N_OUT +: N_OUT].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  row-write request.
- cfg_ready  out  1  row write accepted this cycle when high together with cfg_valid.
- cfg_addr  in  N_IN  row index to write.
- cfg_data  in  N_OUT  row contents.
- in_valid  in  1  evaluate request.
- in_ready  out  1  evaluate handshake.
- in_data  in  N_IN  input vector {w,x,y,z,...}, MSB first.
- sweep_start  in  1  one-cycle request to begin a full sweep.
- sweep_busy  out  1  high while in SWEEP.
- sweep_done  out  1  one-cycle pulse after the last sweep row is accepted.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- out_index  out  N_IN  row index of the result.
- out_data  out  N_OUT  table[out_index].

Behaviour:
- Reset is asynchronous. On reset:
  - table = INIT; state = IDLE.
  - out_valid=0, out_index=0, out_data=0.
  - sweep_busy=0, sweep_done=0.
  - Internal sweep counter = 0.
- Reset mid-sweep aborts the sweep with no done pulse.
- States:
  - IDLE -> SWEEP: on sweep_start && !out_valid. sweep_start is ignored in other states or while out_valid=1.
  - SWEEP -> DONE: when out_valid && out_ready && out_index == DEPTH-1.
  - DONE -> IDLE: unconditionally after one cycle. sweep_done=1 only in DONE.
- Output register: single entry; holds stable while out_valid && !out_ready. out_valid clears on accept unless it is refilled in the same cycle.
- Evaluate:
  - in_ready = (state==IDLE) && !sweep_start && (!out_valid || out_ready).
  - On in_valid && in_ready: next cycle out_valid=1, out_index=in_data, out_data=table[in_data].
  - Latency is 1 cycle; back-to-back throughput is 1 per cycle when out_ready=1.
- Sweep:
  - On entry the counter is 0 and row 0 is loaded into the output register on the next edge.
  - Each accepted row advances the counter and loads the next row in the same cycle, giving full throughput.
  - out_ready low stalls the sweep with the output held.
  - After row DEPTH-1 is accepted, out_valid=0.
- Config:
  - cfg_ready = (state != SWEEP). Writes are allowed in IDLE and DONE.
  - A write takes effect at the clock edge.
  - A same-cycle evaluate of the same address reads the OLD row (read-before-write).
- Simultaneous sweep_start and in_valid in IDLE: the sweep wins and in_valid is not accepted (in_ready=0).
- Index counter is exactly N_IN bits. Wrap from DEPTH-1 is never observed because the FSM leaves SWEEP first.

Optional Feature:
Macro LUT_BREADBOARD_PARITY_EN.
- Defined: adds output out_parity (1 bit) = XOR-reduce of out_data. It is registered with out_data, reset to 0, and held stable under stall.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lut_breadboard_pkg holds:
  - state enum {IDLE, SWEEP, DONE}, 2 bits;
  - function depth_of(n_in) returning 2**n_in.
- One sub-module, lut_breadboard_mem: DEPTH x N_OUT flop array.
  - One synchronous write port.
  - One combinational read port.
  - Asynchronous reset to INIT.
- The top module keeps the FSM, handshakes and output register.

Test Plan:
- Reset with INIT=0; write row 3 = 10'h2A5, then evaluate in_data=3 -> one cycle later out_valid=1, out_index=3, out_data=10'h2A5.
- Evaluate in_data=5 while cfg writes row 5 = 10'h3FF in the same cycle -> out_data=old value 10'h000; a later evaluate of 5 -> 10'h3FF.
- Load rows k = k*10'h041 (mod 1024), pulse sweep_start with out_ready=1 -> 16 consecutive beats, indices 0..15 with matching data; sweep_done pulses one cycle after beat 15; sweep_busy high for exactly 16 cycles.
- Sweep with out_ready low on beats 4 and 9 for 3 cycles each -> out_index/out_data held stable during the stall, no row skipped or duplicated, cfg_ready=0 throughout.
- Assert rst_n low mid-sweep at index 7 (asynchronous, between edges) -> outputs clear immediately, table returns to INIT, no sweep_done pulse; a new sweep restarts from index 0.
- With LUT_BREADBOARD_PARITY_EN defined, row 6 = 10'h007 -> out_parity=1; row 2 = 10'h003 -> out_parity=0.

Source files
------------

// File: rtl/lut_breadboard_pkg.sv
// lut_breadboard_pkg: shared state encoding and sizing helper for the LUT breadboard
package lut_breadboard_pkg;
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction
endpackage

// File: rtl/lut_breadboard_if.sv
// lut_breadboard_if: config, evaluate, sweep and result channels (out_parity under LUT_BREADBOARD_PARITY_EN)
interface lut_breadboard_if #(parameter int N_IN = 4, parameter int N_OUT = 10);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N_IN-1:0]  cfg_addr;
    logic [N_OUT-1:0] cfg_data;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             sweep_start;
    logic             sweep_busy;
    logic             sweep_done;
    logic             out_valid;
    logic             out_ready;
    logic [N_IN-1:0]  out_index;
    logic [N_OUT-1:0] out_data;
`ifdef LUT_BREADBOARD_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output cfg_valid, cfg_addr, cfg_data, in_valid, in_data, sweep_start, out_ready,
        input  cfg_ready, in_ready, sweep_busy, sweep_done, out_valid, out_index, out_data
`ifdef LUT_BREADBOARD_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_data, in_valid, in_data, sweep_start, out_ready,
        output cfg_ready, in_ready, sweep_busy, sweep_done, out_valid, out_index, out_data
`ifdef LUT_BREADBOARD_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/lut_breadboard_mem.sv
// lut_breadboard_mem: DEPTH x N_OUT flop table, one sync write port, one combinational read port
module lut_breadboard_mem
    import lut_breadboard_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 10,
    parameter logic [N_OUT*depth_of(N_IN)-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    input  logic [N_IN-1:0]  rd_addr,
    output logic [N_OUT-1:0] rd_data
);
    localparam int DEPTH = depth_of(N_IN);

    logic [N_OUT-1:0] mem [DEPTH];

    // Reset reloads every row from INIT; otherwise at most one row is written per edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int k = 0; k < DEPTH; k++) mem[k] <= INIT[k*N_OUT +: N_OUT];
        else if (we)
            mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/lut_breadboard.sv
// lut_breadboard: programmable truth table with registered evaluate path and hardware sweep
// Optional out_parity output enabled by defining LUT_BREADBOARD_PARITY_EN.
module lut_breadboard
    import lut_breadboard_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 10,
    parameter logic [N_OUT*depth_of(N_IN)-1:0] INIT = '0
) (
    input logic          clk,
    input logic          rst_n,
    lut_breadboard_if.slave bus
);
    localparam int DEPTH = depth_of(N_IN);
    localparam logic [N_IN-1:0] LAST = N_IN'(DEPTH - 1);

    state_t           state;
    logic [N_IN-1:0]  cnt;
    logic [N_IN-1:0]  rd_addr;
    logic [N_OUT-1:0] rd_data;
    logic             accept;
    logic             start;
    logic             eval_fire;
    logic             last_beat;
    logic             sweep_load;

    assign accept        = bus.out_valid && bus.out_ready;
    assign start         = state == IDLE && bus.sweep_start && !bus.out_valid;
    assign bus.in_ready  = state == IDLE && !bus.sweep_start && (!bus.out_valid || bus.out_ready);
    assign bus.cfg_ready = state != SWEEP;
    assign eval_fire     = bus.in_valid && bus.in_ready;
    assign last_beat     = accept && bus.out_index == LAST;
    assign sweep_load    = state == SWEEP && accept && !last_beat;
    // One read port serves both paths: the next sweep row, row 0 on sweep entry, else the evaluate address.
    assign rd_addr       = state == SWEEP ? cnt + 1'b1 : (start ? '0 : bus.in_data);

    lut_breadboard_mem #(.N_IN(N_IN), .N_OUT(N_OUT), .INIT(INIT)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (bus.cfg_valid && bus.cfg_ready),
        .wr_addr (bus.cfg_addr),
        .wr_data (bus.cfg_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Sweep sequencer; cnt mirrors the index currently held in the output register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.sweep_busy <= 1'b0;
            bus.sweep_done <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start) begin
                        state          <= SWEEP;
                        cnt            <= '0;
                        bus.sweep_busy <= 1'b1;
                    end
                SWEEP:
                    if (last_beat) begin
                        state          <= DONE;
                        cnt            <= '0;
                        bus.sweep_busy <= 1'b0;
                        bus.sweep_done <= 1'b1;
                    end else if (sweep_load) begin
                        cnt <= cnt + 1'b1;
                    end
                DONE: begin
                    state          <= IDLE;
                    bus.sweep_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end

    // Single-entry output register: load wins over drain so back-to-back beats never bubble.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.out_valid  <= 1'b0;
            bus.out_index  <= '0;
            bus.out_data   <= '0;
`ifdef LUT_BREADBOARD_PARITY_EN
            bus.out_parity <= 1'b0;
`endif
        end else if (eval_fire || start || sweep_load) begin
            bus.out_valid  <= 1'b1;
            bus.out_index  <= rd_addr;
            bus.out_data   <= rd_data;
`ifdef LUT_BREADBOARD_PARITY_EN
            bus.out_parity <= ^rd_data;
`endif
        end else if (accept) begin
            bus.out_valid  <= 1'b0;
        end
endmodule
